// File: rtl/csa_mul_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
//   state_t    : controller states (IDLE, ACCUM, RESOLVE, DONE)
//   row_cnt_w  : width of the partial-product row counter for a given operand width
package csa_mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Operand width is constrained to 2..32, so $clog2 is always >= 1.
    function automatic int unsigned row_cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/csa_row.sv
// One carry-save adder row: a column of full-adder cells that compress
// (partial-product row, sum, carry) into (sum', carry').
// Purely combinational.
//   pp        in  2*WIDTH  weighted partial-product row
//   sum_in    in  2*WIDTH  current redundant sum
//   carry_in  in  2*WIDTH  current redundant carry
//   sum_out   out 2*WIDTH  new sum
//   carry_out out 2*WIDTH  new carry, already shifted to its column weight
module csa_row
    import csa_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] pp,
    input  logic [2*WIDTH-1:0] sum_in,
    input  logic [2*WIDTH-1:0] carry_in,
    output logic [2*WIDTH-1:0] sum_out,
    output logic [2*WIDTH-1:0] carry_out
);

    localparam int unsigned PW = 2 * WIDTH;

    // The carry out of the top column is dropped: the result is modulo 2^PW.
    always_comb begin
        sum_out   = '0;
        carry_out = '0;
        for (int unsigned j = 0; j < PW; j++) begin
            sum_out[j] = pp[j] ^ sum_in[j] ^ carry_in[j];
        end
        for (int unsigned j = 0; j < PW - 1; j++) begin
            carry_out[j+1] = (pp[j] & sum_in[j]) | (pp[j] & carry_in[j]) |
                             (sum_in[j] & carry_in[j]);
        end
    end

endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential multiplier: one partial-product row per cycle accumulated in
// carry-save form, then a single carry-propagate add.
// Latency: accept edge is edge 0; rows are consumed on edges 1..WIDTH, the
// final add on edge WIDTH+1, so the product can first be taken on edge WIDTH+2.
// Build option: define CSA_SIGNED_MUL_EN for two's complement operands
// (Baugh-Wooley); otherwise operands are unsigned.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair present
//   in_ready   out  operands can be accepted (IDLE only)
//   a, b       in   WIDTH-bit multiplicand / multiplier
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer takes the product
//   product    out  2*WIDTH-bit result, held until the next result or reset
module csa_seq_multiplier
    import csa_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = row_cnt_w(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

`ifdef CSA_SIGNED_MUL_EN
    // Baugh-Wooley correction constants 2^WIDTH + 2^(2*WIDTH-1), seeded into
    // the sum register so no extra accumulation cycle is needed.
    localparam logic [PW-1:0] SUM_SEED = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`else
    localparam logic [PW-1:0] SUM_SEED = '0;
`endif

    state_t             state, state_next;
    logic [CNT_W-1:0]   row;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   row_bits;
    logic [PW-1:0]      pp, sum_reg, carry_reg, sum_next, carry_next, product_reg;
    logic               last_row;

    assign last_row = (row == CNT_W'(WIDTH - 1));
    assign product  = product_reg;

    // Partial-product row for the current multiplier bit, weighted by 2^row.
    always_comb begin
        row_bits = a_reg & {WIDTH{b_reg[row]}};
`ifdef CSA_SIGNED_MUL_EN
        if (last_row) begin
            row_bits[WIDTH-2:0] = ~row_bits[WIDTH-2:0];
        end else begin
            row_bits[WIDTH-1] = ~row_bits[WIDTH-1];
        end
`endif
        pp = PW'(row_bits) << row;
    end

    csa_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .pp        (pp),
        .sum_in    (sum_reg),
        .carry_in  (carry_reg),
        .sum_out   (sum_next),
        .carry_out (carry_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry_reg   <= '0;
            product_reg <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sum_reg   <= SUM_SEED;
                        carry_reg <= '0;
                        row       <= '0;
                    end
                end
                ACCUM: begin
                    sum_reg   <= sum_next;
                    carry_reg <= carry_next;
                    row       <= last_row ? '0 : row + 1'b1;
                end
                RESOLVE: begin
                    product_reg <= sum_reg + carry_reg;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ACCUM;
            end
            ACCUM: begin
                if (last_row) state_next = RESOLVE;
            end
            RESOLVE: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Directed and random checks of csa_seq_multiplier at WIDTH 8, 2 and 16.
// Latency is counted as the first edge (accept edge = 0) at which out_valid
// is seen high, i.e. the first edge on which the product can be taken.
module tb_csa_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_bus, b_bus;
    int          sel;

    logic        iv8, ir8, ov8;
    logic [15:0] p8;
    logic        iv2, ir2, ov2;
    logic [3:0]  p2;
    logic        iv16, ir16, ov16;
    logic [31:0] p16;

    logic        ir, ov;
    logic [31:0] prod;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign iv8  = in_valid && (sel == 8);
    assign iv2  = in_valid && (sel == 2);
    assign iv16 = in_valid && (sel == 16);

    always_comb begin
        ir   = ir8;
        ov   = ov8;
        prod = {16'h0, p8};
        if (sel == 2) begin
            ir = ir2; ov = ov2; prod = {28'h0, p2};
        end else if (sel == 16) begin
            ir = ir16; ov = ov16; prod = p16;
        end
    end

    csa_seq_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .out_valid(ov8),
        .out_ready(out_ready), .product(p8)
    );

    csa_seq_multiplier #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a_bus[1:0]), .b(b_bus[1:0]), .out_valid(ov2),
        .out_ready(out_ready), .product(p2)
    );

    csa_seq_multiplier #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a_bus), .b(b_bus), .out_valid(ov16),
        .out_ready(out_ready), .product(p16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av, input logic [15:0] bv);
        longint m = (longint'(1) << w) - 1;
        longint x = longint'(av) & m;
        longint y = longint'(bv) & m;
        longint p;
`ifdef CSA_SIGNED_MUL_EN
        if (x[w-1]) x = x - (longint'(1) << w);
        if (y[w-1]) y = y - (longint'(1) << w);
`endif
        p = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    // Full transaction on the instance chosen by sel. Starts and ends at a negedge.
    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input bit toggle, input int hold);
        int lat;
        check({tag, "_in_ready"}, 32'(ir), 32'd1);
        a_bus     = av;
        b_bus     = bv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (toggle) begin
                a_bus = 16'($urandom);
                b_bus = 16'($urandom);
            end
            if (ov) begin
                lat = k;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(sel + 2));
        check({tag, "_product"}, prod, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_product"}, prod, exp);
            check({tag, "_hold_in_ready"}, 32'(ir), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 32'(ov), 32'd0);
        check({tag, "_post_in_ready"}, 32'(ir), 32'd1);
        check({tag, "_idle_product"}, prod, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_bus     = '0;
        b_bus     = '0;
        sel       = 8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(ir8), 32'd1);
        check("reset_out_valid", 32'(ov8), 32'd0);
        check("reset_product", 32'(p8), 32'd0);
        rst = 1'b0;

        do_op("ff_ff", 16'h00FF, 16'h00FF,
`ifdef CSA_SIGNED_MUL_EN
              32'h0001,
`else
              32'hFE01,
`endif
              1'b0, 0);
        do_op("hold_3x5", 16'h0003, 16'h0005, 32'h000F, 1'b0, 20);
        do_op("zero_a", 16'h0000, 16'h005A, 32'h0000, 1'b0, 0);
        do_op("zero_b", 16'h005A, 16'h0000, 32'h0000, 1'b0, 0);
        do_op("12x34", 16'h0012, 16'h0034, 32'h03A8, 1'b0, 0);
        do_op("80x02", 16'h0080, 16'h0002,
`ifdef CSA_SIGNED_MUL_EN
              32'hFF00,
`else
              32'h0100,
`endif
              1'b0, 0);
`ifdef CSA_SIGNED_MUL_EN
        do_op("s_80x7f", 16'h0080, 16'h007F, 32'hC080, 1'b0, 0);
        do_op("s_80x80", 16'h0080, 16'h0080, 32'h4000, 1'b0, 0);
`endif
        do_op("toggle_0cx0a", 16'h000C, 16'h000A, 32'h0078, 1'b1, 0);

        // Reset while row 4 is pending in ACCUM: the operation must vanish.
        a_bus    = 16'h0055;
        b_bus    = 16'h0055;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_accum_in_ready", 32'(ir8), 32'd1);
        check("rst_accum_out_valid", 32'(ov8), 32'd0);
        check("rst_accum_product", 32'(p8), 32'd0);
        do_op("after_rst_2x3", 16'h0002, 16'h0003, 32'h0006, 1'b0, 0);

        // Reset while waiting in DONE.
        a_bus    = 16'h0003;
        b_bus    = 16'h0005;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("done_before_rst", 32'(ov8), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_out_valid", 32'(ov8), 32'd0);
        check("rst_done_product", 32'(p8), 32'd0);

        sel = 2;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 3));
            rb = 16'($urandom_range(0, 3));
            do_op("rand_w2", ra, rb, ref_mul(2, ra, rb), 1'b0, 0);
        end

        sel = 16;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op("rand_w16", ra, rb, ref_mul(16, ra, rb), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_seq_multiplier.md
CSA_SEQ_MULTIPLIER -- requirements
Module: csa_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair present on a/b.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port out_valid  output  1  product is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-010 SHALL have port product  output  2*WIDTH  result.

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, RESOLVE and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 SHALL register a and b on the accept edge (in_valid & in_ready), then go IDLE->ACCUM; later changes on a/b SHALL be ignored.
REQ-014 SHALL, in ACCUM, add one partial-product row (a & {WIDTH{b[i]}}, weighted 2^i) per cycle into carry-save sum/carry registers, i = 0..WIDTH-1, using a row counter.
REQ-015 SHALL go ACCUM->RESOLVE on the edge that processes row WIDTH-1.
REQ-016 SHALL, in RESOLVE, perform one carry-propagate add of sum and carry into the product register, then go RESOLVE->DONE.
REQ-017 SHALL assert out_valid on the (WIDTH+2)th rising edge after the accept edge, where the accept edge is edge 0; for WIDTH=8 this is edge 10.
REQ-018 SHALL hold product stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-019 SHALL go DONE->IDLE on the edge with out_valid & out_ready; in_ready SHALL rise in the following cycle, so there is no same-cycle re-accept.
REQ-020 SHALL produce product = a*b modulo 2^(2*WIDTH), with no overflow possible; b=0 or a=0 SHALL yield 0 after the full latency, with no early exit.
REQ-021 SHALL hold the last product value on the product port in IDLE; it is don't-care while out_valid=0.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, force IDLE and clear the row counter, the sum/carry registers, the operand registers and product (all zero).
REQ-023 SHALL give rst priority over every handshake; a rst mid-ACCUM, mid-RESOLVE or in DONE SHALL discard the operation without producing a product.
REQ-024 SHALL, in the cycle after reset, drive in_ready=1, out_valid=0 and product=0.

Configuration
REQ-025 SHALL, with macro CSA_SIGNED_MUL_EN defined, treat a and b as two's complement (Baugh-Wooley: invert MSB cross terms, add correction constants) and produce the signed product.
REQ-026 SHALL, without CSA_SIGNED_MUL_EN, treat a and b as unsigned; latency and handshake SHALL be identical in both builds.

Structure
REQ-027 SHALL place the state enum typedef, the state encoding and the row-counter width localparam ($clog2(WIDTH)) in a shared package csa_mul_pkg.
REQ-028 SHALL instantiate one combinational sub-module csa_row (parameter WIDTH), an array of 3-input carry-save cells mapping (pp row, sum, carry) to (sum', carry'), as the per-cycle datapath.

Verification
REQ-029 SHALL cover: unsigned build, WIDTH=8, a=0xFF, b=0xFF -> product=0xFE01, out_valid at edge 10.
REQ-030 SHALL cover: signed build, WIDTH=8, a=0x80, b=0x7F -> product=0xC080; and a=0xFF, b=0xFF -> 0x0001; and a=0x80, b=0x80 -> 0x4000.
REQ-031 SHALL cover: a=0x03, b=0x05 accepted, out_ready held 0 for 20 cycles -> product=0x000F stable throughout, in_ready=0; product then accepted, and in_ready=1 one cycle later.
REQ-032 SHALL cover: rst pulsed at row 4 of ACCUM -> next cycle in_ready=1, out_valid=0, product=0; a new 0x02*0x03 then yields 0x0006.
REQ-033 SHALL cover: a/b toggled randomly after accept of 0x0C*0x0A -> product=0x0078.
REQ-034 SHALL cover: WIDTH=2 and WIDTH=16, 200 random pairs each against a reference model, with latency checked at WIDTH+2.
